ppu_pix_mixer: RTL
==================

Name: ppu_pix_mixer

Overview:
- Parametrised successor to the PPU's inline palette/priority logic. It takes background and sprite palette indices for the current pixel and applies per-layer enable and left-column clipping.
- It resolves sprite/background priority, looks the result up in an internal mirrored palette RAM, and emits a registered system-palette colour to the VGA block.
- It also owns the CPU-side palette RAM port, the sticky sprite-0 hit flag, and greyscale mode.

Parameters:
- IDX_W, 4, per-layer palette index width; bits [1:0] are the pixel value (0 = transparent), upper bits are the sub-palette.
- COLOR_W, 6, system palette colour width.
- X_W, 10, pixel x-coordinate width.
- CLIP_PIX, 8, number of leftmost pixels hidden when a clip input is set.
- LAST_X, 255, x coordinate on which sprite-0 hit never triggers.
- GREY_MASK, 6'h30, AND-mask applied to the colour in greyscale mode (width COLOR_W).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- pix_pulse_in  in  1  one-cycle strobe: pixel inputs below are valid
- nes_x_in  in  X_W  x of current pixel
- frame_start_in  in  1  one-cycle pulse at pre-render line; clears sprite-0 hit
- bg_idx_in  in  IDX_W  background palette index
- spr_idx_in  in  IDX_W  sprite palette index
- spr_pri_in  in  1  1 = sprite behind background
- spr_zero_in  in  1  sprite pixel originates from OAM entry 0
- bg_en_in  in  1  background enable
- spr_en_in  in  1  sprite enable
- bg_clip_in  in  1  1 = hide background for x < CLIP_PIX
- spr_clip_in  in  1  1 = hide sprites for x < CLIP_PIX
- grey_in  in  1  greyscale mode
- pram_a_in  in  IDX_W+1  CPU palette address
- pram_d_in  in  COLOR_W  CPU palette write data
- pram_wr_in  in  1  CPU palette write strobe
- pram_d_out  out  COLOR_W  CPU palette read data (registered)
- color_out  out  COLOR_W  system palette colour
- color_vld_out  out  1  color_out valid strobe
- spr0_hit_out  out  1  sticky sprite-0 hit flag

Behaviour:

- Clock and reset:
  - One clock, clk_in. rst_in is synchronous and active-high.
  - On reset: color_out=0, color_vld_out=0, spr0_hit_out=0, pram_d_out=0, all 2^(IDX_W+1) palette entries = 0, both pipeline valid bits = 0.
  - Reset asserted mid-pipeline drops in-flight pixels; no color_vld_out pulse follows.

- Palette RAM:
  - Size 2^(IDX_W+1) x COLOR_W.
  - Mirror function M(a): if a[1:0]==0 and a[IDX_W]==1, clear a[IDX_W]; otherwise unchanged. With IDX_W=4, 0x10/0x14/0x18/0x1C map to 0x00/0x04/0x08/0x0C.
  - All reads and writes go through M.
  - Write: when pram_wr_in=1, pram[M(pram_a_in)] <= pram_d_in at the clock edge.
  - CPU read: pram_d_out <= pram[M(pram_a_in)] every cycle. The read is read-before-write, so it returns the old value when a write to the same address occurs in the same cycle.

- Stage 1 (registered on pix_pulse_in):
  - clip = (nes_x_in < CLIP_PIX).
  - bg_op = bg_en_in & ~(bg_clip_in & clip) & |bg_idx_in[1:0].
  - spr_op = spr_en_in & ~(spr_clip_in & clip) & |spr_idx_in[1:0].
  - Selected address:
    - if spr_op & (~spr_pri_in | ~bg_op): {1, spr_idx_in}
    - else if bg_op: {0, bg_idx_in}
    - else: 0 (backdrop).
  - Register the address and s1_vld=1. s1_vld=0 on cycles without pix_pulse_in.
  - Sprite-0 hit: set spr0_hit_out when pix_pulse_in & spr_zero_in & spr_op & bg_op & (nes_x_in != LAST_X). Sprite priority is irrelevant to the hit.
  - The hit stays set until frame_start_in. frame_start_in wins if it arrives in the same cycle as a hit condition.

- Stage 2:
  - c = pram[M(s1_addr)], read-before-write against a same-cycle CPU write.
  - color_out <= grey_in ? (c & GREY_MASK) : c.
  - color_vld_out <= s1_vld.
  - grey_in is sampled at stage 2.
  - color_out holds its value when color_vld_out=0.

- Latency and throughput:
  - Latency is exactly 2 clocks from pix_pulse_in to color_vld_out.
  - Back-to-back pix_pulse_in is supported at one pixel per clock.
  - Outputs keep input order; the block has no backpressure.

Test Plan:
- Reset, then set pram[0]=0x0F and pram[0x11]=0x16. Pulse with bg_idx=0, spr_idx=1, spr_en=1, spr_pri=0, x=20 -> two cycles later color_vld_out=1, color_out=0x16.
- bg_idx=5 (pram[5]=0x21), spr_idx=1, spr_pri=1, both enabled -> color_out=0x21. Then set spr_pri=0 -> color_out=0x16.
- Mirroring: write 0x2A to 0x10 -> reading 0x00 gives pram_d_out=0x2A. A backdrop pixel then yields color_out=0x2A. Writing 0x2A to 0x11 leaves 0x01 unchanged.
- Clipping: spr_clip=1, bg_clip=1, x=7, both opaque -> backdrop colour. At x=8 -> sprite/background resolution applies.
- Sprite-0 hit:
  - spr_zero=1, both opaque, x=255 -> spr0_hit_out stays 0.
  - At x=100 -> spr0_hit_out=1 from the next cycle and held.
  - frame_start_in together with another hit condition -> spr0_hit_out=0.
- Greyscale, collisions and reset:
  - grey_in=1 with colour 0x16 -> color_out=0x10.
  - CPU write to the address being looked up in stage 2 -> old colour output and old pram_d_out.
  - Reset asserted between pulse and output -> no color_vld_out.

Source files
------------

// File: rtl/ppu_pix_mixer.sv
// ppu_pix_mixer: per-pixel background/sprite mixer with mirrored palette RAM.
// A two-stage pipeline resolves layer visibility and priority, then looks the
// winning index up in palette RAM. The block also owns the CPU palette port,
// the sticky sprite-0 hit flag and greyscale masking.
module ppu_pix_mixer #(
    parameter int unsigned        IDX_W     = 4,
    parameter int unsigned        COLOR_W   = 6,
    parameter int unsigned        X_W       = 10,
    parameter int unsigned        CLIP_PIX  = 8,
    parameter int unsigned        LAST_X    = 255,
    parameter logic [COLOR_W-1:0] GREY_MASK = COLOR_W'(6'h30)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               pix_pulse_in,
    input  logic [X_W-1:0]     nes_x_in,
    input  logic               frame_start_in,
    input  logic [IDX_W-1:0]   bg_idx_in,
    input  logic [IDX_W-1:0]   spr_idx_in,
    input  logic               spr_pri_in,
    input  logic               spr_zero_in,
    input  logic               bg_en_in,
    input  logic               spr_en_in,
    input  logic               bg_clip_in,
    input  logic               spr_clip_in,
    input  logic               grey_in,
    input  logic [IDX_W:0]     pram_a_in,
    input  logic [COLOR_W-1:0] pram_d_in,
    input  logic               pram_wr_in,
    output logic [COLOR_W-1:0] pram_d_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               color_vld_out,
    output logic               spr0_hit_out
);

    localparam int unsigned A_W   = IDX_W + 1;
    localparam int unsigned DEPTH = 2 ** A_W;

    // Entry 0 of every sprite sub-palette aliases the matching background entry.
    function automatic logic [A_W-1:0] mirror(input logic [A_W-1:0] a);
        logic [A_W-1:0] m;
        m = a;
        if (a[1:0] == 2'b00) begin
            m[IDX_W] = 1'b0;
        end
        return m;
    endfunction

    logic [COLOR_W-1:0] pram [DEPTH];

    logic               clip_c;
    logic               bg_op_c;
    logic               spr_op_c;
    logic               hit_c;
    logic [A_W-1:0]     sel_addr_c;
    logic [COLOR_W-1:0] lookup_c;

    logic               s1_vld;
    logic [A_W-1:0]     s1_addr;

    // Stage-1 decode: layer visibility, priority resolution and hit detection.
    always_comb begin
        clip_c     = (nes_x_in < X_W'(CLIP_PIX));
        bg_op_c    = bg_en_in & ~(bg_clip_in & clip_c) & (|bg_idx_in[1:0]);
        spr_op_c   = spr_en_in & ~(spr_clip_in & clip_c) & (|spr_idx_in[1:0]);
        sel_addr_c = '0;
        if (spr_op_c & (~spr_pri_in | ~bg_op_c)) begin
            sel_addr_c = {1'b1, spr_idx_in};
        end else if (bg_op_c) begin
            sel_addr_c = {1'b0, bg_idx_in};
        end
        hit_c = pix_pulse_in & spr_zero_in & spr_op_c & bg_op_c
              & (nes_x_in != X_W'(LAST_X));
    end

    // Stage-1 register: palette address of the winning layer.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
        end else begin
            s1_vld <= pix_pulse_in;
            if (pix_pulse_in) begin
                s1_addr <= sel_addr_c;
            end
        end
    end

    // Sticky sprite-0 hit; a frame start takes precedence over a new hit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            spr0_hit_out <= 1'b0;
        end else if (frame_start_in) begin
            spr0_hit_out <= 1'b0;
        end else if (hit_c) begin
            spr0_hit_out <= 1'b1;
        end
    end

    // CPU palette port: registered read-before-write through the mirror map.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pram[i] <= '0;
            end
            pram_d_out <= '0;
        end else begin
            pram_d_out <= pram[mirror(pram_a_in)];
            if (pram_wr_in) begin
                pram[mirror(pram_a_in)] <= pram_d_in;
            end
        end
    end

    // Stage-2 palette lookup sees the array contents before any same-cycle write.
    always_comb begin
        lookup_c = pram[mirror(s1_addr)];
    end

    // Stage-2 register: colour output with optional greyscale masking.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            color_out     <= '0;
            color_vld_out <= 1'b0;
        end else begin
            color_vld_out <= s1_vld;
            if (s1_vld) begin
                color_out <= grey_in ? (lookup_c & GREY_MASK) : lookup_c;
            end
        end
    end

endmodule
